// File: rtl/reg_writeback.sv
// reg_writeback: writeback stage sitting directly in front of register_file.
// It owns the single register-file write port and merges two result sources:
//   - the ALU, one result per cycle with no backpressure (always wins), and
//   - the load unit, a valid/ready stream buffered in a small in-order FIFO.
// Each buffered load carries a live bit. A newer ALU write to the same rd
// clears that bit, so a stale load can never overwrite a newer result.
// Results addressed to x0 are never written.
// Optional feature: define REG_WRITEBACK_FWD_EN to enable write-then-read
// forwarding from the output registers. Without it the fwd_* outputs are
// tied to zero.

module reg_writeback #(
    parameter int DATA_WIDTH    = 32,
    parameter int LD_FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               alu_valid,
    input  logic [4:0]                         alu_rd,
    input  logic [DATA_WIDTH-1:0]              alu_data,
    input  logic                               ld_valid,
    output logic                               ld_ready,
    input  logic [4:0]                         ld_rd,
    input  logic [DATA_WIDTH-1:0]              ld_data,
    output logic                               wr_en,
    output logic [4:0]                         wr_index,
    output logic [DATA_WIDTH-1:0]              wr_data,
    output logic                               ld_pending,
    output logic [$clog2(LD_FIFO_DEPTH):0]     ld_count,
    input  logic [4:0]                         fwd_index1,
    input  logic [4:0]                         fwd_index2,
    output logic                               fwd_hit1,
    output logic                               fwd_hit2,
    output logic [DATA_WIDTH-1:0]              fwd_data1,
    output logic [DATA_WIDTH-1:0]              fwd_data2
);

    localparam int PTR_W = $clog2(LD_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Load buffer storage and bookkeeping
    logic [4:0]              fifo_rd_r   [LD_FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_data_r [LD_FIFO_DEPTH];
    logic [LD_FIFO_DEPTH-1:0] fifo_live_r;
    logic [PTR_W-1:0]        head_r;
    logic [PTR_W-1:0]        tail_r;
    logic [CNT_W-1:0]        count_r;

    // Registered write port
    logic                    wr_en_r;
    logic [4:0]              wr_index_r;
    logic [DATA_WIDTH-1:0]   wr_data_r;

    // Per-cycle decisions
    logic                    alu_wr_s;
    logic                    fifo_empty_s;
    logic                    ld_ready_s;
    logic                    ld_acc_s;
    logic                    ld_nz_s;
    logic                    ld_waw_s;
    logic                    pop_s;
    logic                    bypass_s;
    logic                    push_s;
    logic [4:0]              head_rd_s;
    logic [DATA_WIDTH-1:0]   head_data_s;
    logic                    head_live_s;

    // Next values for the write port
    logic                    nxt_wr_en_s;
    logic [4:0]              nxt_wr_index_s;
    logic [DATA_WIDTH-1:0]   nxt_wr_data_s;

    // Forwarding results
    logic                    fwd_hit1_s;
    logic                    fwd_hit2_s;
    logic [DATA_WIDTH-1:0]   fwd_data1_s;
    logic [DATA_WIDTH-1:0]   fwd_data2_s;

    // Arbitration: ALU first, then FIFO head, then same-cycle load bypass
    always_comb begin
        head_rd_s    = fifo_rd_r[head_r];
        head_data_s  = fifo_data_r[head_r];
        head_live_s  = fifo_live_r[head_r];
        alu_wr_s     = alu_valid && (alu_rd != 5'd0);
        fifo_empty_s = (count_r == {CNT_W{1'b0}});
        // Readiness depends only on current occupancy; a same-cycle pop
        // does not open a slot.
        ld_ready_s   = !reset && (count_r < CNT_W'(LD_FIFO_DEPTH));
        ld_acc_s     = ld_valid && ld_ready_s;
        ld_nz_s      = (ld_rd != 5'd0);
        // A load arriving with an ALU result to the same rd is the older of
        // the two, so it is acknowledged and discarded.
        ld_waw_s     = alu_wr_s && (ld_rd == alu_rd);
        pop_s        = !alu_wr_s && !fifo_empty_s;
        bypass_s     = !alu_wr_s && fifo_empty_s && ld_acc_s && ld_nz_s;
        push_s       = ld_acc_s && ld_nz_s && !bypass_s && !ld_waw_s;
    end

    // Select the value that the write port registers on the next edge
    always_comb begin
        nxt_wr_en_s    = 1'b0;
        nxt_wr_index_s = 5'd0;
        nxt_wr_data_s  = {DATA_WIDTH{1'b0}};
        if (alu_wr_s) begin
            nxt_wr_en_s    = 1'b1;
            nxt_wr_index_s = alu_rd;
            nxt_wr_data_s  = alu_data;
        end else if (pop_s) begin
            // A killed entry still takes its pop slot but writes nothing.
            if (head_live_s) begin
                nxt_wr_en_s    = 1'b1;
                nxt_wr_index_s = head_rd_s;
                nxt_wr_data_s  = head_data_s;
            end else begin
                nxt_wr_en_s    = 1'b0;
                nxt_wr_index_s = 5'd0;
                nxt_wr_data_s  = {DATA_WIDTH{1'b0}};
            end
        end else if (bypass_s) begin
            nxt_wr_en_s    = 1'b1;
            nxt_wr_index_s = ld_rd;
            nxt_wr_data_s  = ld_data;
        end else begin
            nxt_wr_en_s    = 1'b0;
            nxt_wr_index_s = 5'd0;
            nxt_wr_data_s  = {DATA_WIDTH{1'b0}};
        end
    end

    // Load FIFO: WAW kill, in-order pop, tail enqueue and occupancy count
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r      <= {PTR_W{1'b0}};
            tail_r      <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            fifo_live_r <= {LD_FIFO_DEPTH{1'b0}};
            for (int i = 0; i < LD_FIFO_DEPTH; i++) begin
                fifo_rd_r[i]   <= 5'd0;
                fifo_data_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < LD_FIFO_DEPTH; i++) begin
                if (alu_wr_s && (fifo_rd_r[i] == alu_rd)) begin
                    fifo_live_r[i] <= 1'b0;
                end
            end
            // Pop and push never address the same slot: a pop needs a
            // non-empty FIFO and a push a non-full one.
            if (pop_s) begin
                fifo_live_r[head_r] <= 1'b0;
                head_r              <= head_r + PTR_W'(1'b1);
            end
            if (push_s) begin
                fifo_rd_r[tail_r]   <= ld_rd;
                fifo_data_r[tail_r] <= ld_data;
                fifo_live_r[tail_r] <= 1'b1;
                tail_r              <= tail_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Register-file write port register
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_r    <= 1'b0;
            wr_index_r <= 5'd0;
            wr_data_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            wr_en_r    <= nxt_wr_en_s;
            wr_index_r <= nxt_wr_index_s;
            wr_data_r  <= nxt_wr_data_s;
        end
    end

`ifdef REG_WRITEBACK_FWD_EN
    // Forward the value being written this cycle to matching read ports
    always_comb begin
        fwd_hit1_s = wr_en_r && (wr_index_r != 5'd0) && (wr_index_r == fwd_index1);
        fwd_hit2_s = wr_en_r && (wr_index_r != 5'd0) && (wr_index_r == fwd_index2);
        if (fwd_hit1_s) begin
            fwd_data1_s = wr_data_r;
        end else begin
            fwd_data1_s = {DATA_WIDTH{1'b0}};
        end
        if (fwd_hit2_s) begin
            fwd_data2_s = wr_data_r;
        end else begin
            fwd_data2_s = {DATA_WIDTH{1'b0}};
        end
    end
`else
    logic fwd_unused_s;

    // Forwarding disabled: lookup indices are ignored, outputs held at zero
    always_comb begin
        fwd_unused_s = ^{fwd_index1, fwd_index2};
        fwd_hit1_s   = 1'b0;
        fwd_hit2_s   = 1'b0;
        fwd_data1_s  = {DATA_WIDTH{1'b0}};
        fwd_data2_s  = {DATA_WIDTH{1'b0}};
    end
`endif

    assign ld_ready   = ld_ready_s;
    assign ld_count   = count_r;
    assign ld_pending = !fifo_empty_s;
    assign wr_en      = wr_en_r;
    assign wr_index   = wr_index_r;
    assign wr_data    = wr_data_r;
    assign fwd_hit1   = fwd_hit1_s;
    assign fwd_hit2   = fwd_hit2_s;
    assign fwd_data1  = fwd_data1_s;
    assign fwd_data2  = fwd_data2_s;

    reg_writeback_chk #(
        .LD_FIFO_DEPTH (LD_FIFO_DEPTH)
    ) u_chk (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en_r),
        .wr_index (wr_index_r),
        .ld_ready (ld_ready_s),
        .ld_count (count_r)
    );

endmodule

// reg_writeback_chk: structural invariants of the writeback stage.
module reg_writeback_chk #(
    parameter int LD_FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [4:0]                     wr_index,
    input  logic                           ld_ready,
    input  logic [$clog2(LD_FIFO_DEPTH):0] ld_count
);

    localparam int CNT_W = $clog2(LD_FIFO_DEPTH) + 1;

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        ld_count <= CNT_W'(LD_FIFO_DEPTH));

    a_never_x0: assert property (@(posedge clk) disable iff (reset)
        wr_en |-> (wr_index != 5'd0));

    a_ready_not_full: assert property (@(posedge clk) disable iff (reset)
        ld_ready |-> (ld_count < CNT_W'(LD_FIFO_DEPTH)));

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: reset, ALU write, load bypass, FIFO
// backpressure and ordering, WAW kill, x0 drop, forwarding and mid-run reset.
module tb_reg_writeback;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        wr_en;
    logic [4:0]  wr_index;
    logic [31:0] wr_data;
    logic        ld_pending;
    logic [2:0]  ld_count;
    logic [4:0]  fwd_index1;
    logic [4:0]  fwd_index2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;

    int checks;
    int failures;

    reg_writeback #(.DATA_WIDTH(32), .LD_FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .wr_en      (wr_en),
        .wr_index   (wr_index),
        .wr_data    (wr_data),
        .ld_pending (ld_pending),
        .ld_count   (ld_count),
        .fwd_index1 (fwd_index1),
        .fwd_index2 (fwd_index2),
        .fwd_hit1   (fwd_hit1),
        .fwd_hit2   (fwd_hit2),
        .fwd_data1  (fwd_data1),
        .fwd_data2  (fwd_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
        ld_valid  = 1'b0; ld_rd  = 5'd0; ld_data  = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        fwd_index1 = 5'd0; fwd_index2 = 5'd0;
        tick(); tick();
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%0h exp=0", wr_en); end
        checks++; if (wr_index !== 5'd0 || wr_data !== 32'h0) begin failures++; $display("FAIL reset_wr got=%0h/%0h exp=0/0", wr_index, wr_data); end
        checks++; if (ld_count !== 3'd0 || ld_pending !== 1'b0) begin failures++; $display("FAIL reset_count got=%0h/%0h exp=0/0", ld_count, ld_pending); end
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0h exp=0", ld_ready); end
        checks++; if (fwd_hit1 !== 1'b0 || fwd_data1 !== 32'h0) begin failures++; $display("FAIL reset_fwd got=%0h/%0h exp=0/0", fwd_hit1, fwd_data1); end
        reset = 1'b0;
        #1;
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%0h exp=1", ld_ready); end
    endtask

    task automatic test_alu_write();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h55;
        tick();
        idle_inputs();
        checks++; if (wr_en !== 1'b1 || wr_index !== 5'd5 || wr_data !== 32'h55) begin failures++; $display("FAIL alu_write got=%0h/%0h/%0h exp=1/5/55", wr_en, wr_index, wr_data); end
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL alu_ready got=%0h exp=1", ld_ready); end
    endtask

    task automatic test_bypass();
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hA7;
        tick();
        idle_inputs();
        checks++; if (wr_en !== 1'b1 || wr_index !== 5'd7 || wr_data !== 32'hA7) begin failures++; $display("FAIL bypass_write got=%0h/%0h/%0h exp=1/7/a7", wr_en, wr_index, wr_data); end
        checks++; if (ld_count !== 3'd0) begin failures++; $display("FAIL bypass_count got=%0h exp=0", ld_count); end
        tick();
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL bypass_idle got=%0h exp=0", wr_en); end
    endtask

    // ALU busy for 8 cycles while loads 9..13 are offered; FIFO fills at 4,
    // then drains 9..12 and finally 13, which is accepted once a slot frees.
    task automatic test_backpressure();
        logic        exp_en;
        logic [4:0]  exp_idx;
        logic [31:0] exp_data;
        for (int c = 0; c < 14; c++) begin
            alu_valid = (c < 8);
            alu_rd    = 5'(c + 1);
            alu_data  = 32'h10 + 32'(c + 1);
            ld_valid  = (c < 10);
            ld_rd     = (c < 4) ? 5'(9 + c) : 5'd13;
            ld_data   = 32'h100 + 32'(ld_rd);
            tick();
            exp_en   = (c < 13);
            exp_idx  = (c < 13) ? 5'(c + 1) : 5'd0;
            exp_data = (c < 8) ? (32'h10 + 32'(c + 1)) : ((c < 13) ? (32'h100 + 32'(c + 1)) : 32'h0);
            checks++;
            if (wr_en !== exp_en || wr_index !== exp_idx || wr_data !== exp_data) begin
                failures++;
                $display("FAIL bp_write_c%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", c, wr_en, wr_index, wr_data, exp_en, exp_idx, exp_data);
            end
            if (c == 3 || c == 7) begin
                checks++; if (ld_count !== 3'd4 || ld_ready !== 1'b0) begin failures++; $display("FAIL bp_full_c%0d got=%0h/%0h exp=4/0", c, ld_count, ld_ready); end
            end
            if (c == 8 || c == 9) begin
                checks++; if (ld_count !== 3'd3 || ld_ready !== 1'b1) begin failures++; $display("FAIL bp_drain_c%0d got=%0h/%0h exp=3/1", c, ld_count, ld_ready); end
            end
            if (c == 12) begin
                checks++; if (ld_count !== 3'd0 || ld_pending !== 1'b0) begin failures++; $display("FAIL bp_empty got=%0h/%0h exp=0/0", ld_count, ld_pending); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_waw_kill();
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h20;
        ld_valid  = 1'b1; ld_rd  = 5'd3;  ld_data  = 32'h33;
        tick();
        checks++; if (ld_count !== 3'd1 || wr_index !== 5'd20) begin failures++; $display("FAIL waw_buffer got=%0h/%0h exp=1/14", ld_count, wr_index); end
        ld_valid = 1'b0;
        alu_rd = 5'd3; alu_data = 32'h99;
        tick();
        alu_valid = 1'b0;
        checks++; if (wr_en !== 1'b1 || wr_index !== 5'd3 || wr_data !== 32'h99) begin failures++; $display("FAIL waw_alu got=%0h/%0h/%0h exp=1/3/99", wr_en, wr_index, wr_data); end
        tick();
        checks++; if (wr_en !== 1'b0 || ld_count !== 3'd0) begin failures++; $display("FAIL waw_dead_pop got=%0h/%0h exp=0/0", wr_en, ld_count); end
        // same-cycle ALU and load to the same rd: the load is dropped
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
        ld_valid  = 1'b1; ld_rd  = 5'd6; ld_data  = 32'h77;
        tick();
        idle_inputs();
        checks++; if (wr_data !== 32'h66 || ld_count !== 3'd0) begin failures++; $display("FAIL waw_same_cycle got=%0h/%0h exp=66/0", wr_data, ld_count); end
        tick();
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL waw_same_after got=%0h exp=0", wr_en); end
    endtask

    task automatic test_x0();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFF;
        ld_valid  = 1'b1; ld_rd  = 5'd0; ld_data  = 32'hEE;
        #1;
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL x0_ack got=%0h exp=1", ld_ready); end
        tick();
        idle_inputs();
        checks++; if (wr_en !== 1'b0 || ld_count !== 3'd0) begin failures++; $display("FAIL x0_drop got=%0h/%0h exp=0/0", wr_en, ld_count); end
        tick();
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL x0_after got=%0h exp=0", wr_en); end
        // ALU to x0 does not block a load bypass
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFF;
        ld_valid  = 1'b1; ld_rd  = 5'd8; ld_data  = 32'h88;
        tick();
        idle_inputs();
        checks++; if (wr_en !== 1'b1 || wr_index !== 5'd8 || wr_data !== 32'h88) begin failures++; $display("FAIL x0_bypass got=%0h/%0h/%0h exp=1/8/88", wr_en, wr_index, wr_data); end
    endtask

    task automatic test_forward();
        logic        exp_hit;
        logic [31:0] exp_data;
`ifdef REG_WRITEBACK_FWD_EN
        exp_hit = 1'b1; exp_data = 32'h44;
`else
        exp_hit = 1'b0; exp_data = 32'h0;
`endif
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
        tick();
        idle_inputs();
        fwd_index1 = 5'd4; fwd_index2 = 5'd0;
        #1;
        checks++; if (fwd_hit1 !== exp_hit || fwd_data1 !== exp_data) begin failures++; $display("FAIL fwd_port1 got=%0h/%0h exp=%0h/%0h", fwd_hit1, fwd_data1, exp_hit, exp_data); end
        checks++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 32'h0) begin failures++; $display("FAIL fwd_port2_x0 got=%0h/%0h exp=0/0", fwd_hit2, fwd_data2); end
        fwd_index1 = 5'd9; fwd_index2 = 5'd4;
        #1;
        checks++; if (fwd_hit2 !== exp_hit || fwd_data2 !== exp_data || fwd_hit1 !== 1'b0) begin failures++; $display("FAIL fwd_port2 got=%0h/%0h/%0h exp=%0h/%0h/0", fwd_hit2, fwd_data2, fwd_hit1, exp_hit, exp_data); end
        tick();
        checks++; if (fwd_hit2 !== 1'b0) begin failures++; $display("FAIL fwd_idle got=%0h exp=0", fwd_hit2); end
        fwd_index1 = 5'd0; fwd_index2 = 5'd0;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 2; c++) begin
            alu_valid = 1'b1; alu_rd = 5'(21 + c); alu_data = 32'h21;
            ld_valid  = 1'b1; ld_rd  = 5'(25 + c); ld_data  = 32'h25;
            tick();
        end
        idle_inputs();
        checks++; if (ld_count !== 3'd2) begin failures++; $display("FAIL mid_fill got=%0h exp=2", ld_count); end
        reset = 1'b1;
        #1;
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL mid_ready got=%0h exp=0", ld_ready); end
        tick();
        checks++; if (wr_en !== 1'b0 || ld_count !== 3'd0) begin failures++; $display("FAIL mid_reset got=%0h/%0h exp=0/0", wr_en, ld_count); end
        reset = 1'b0;
        tick();
        checks++; if (wr_en !== 1'b0 || ld_pending !== 1'b0) begin failures++; $display("FAIL mid_discard got=%0h/%0h exp=0/0", wr_en, ld_pending); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle_inputs();
        fwd_index1 = 5'd0;
        fwd_index2 = 5'd0;
        test_reset();
        test_alu_write();
        test_bypass();
        test_backpressure();
        test_waw_kill();
        test_x0();
        test_forward();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Writeback stage directly upstream of register_file; owns its single write port (wr_en/wr_index/wr_data).
- Merges two result sources: ALU (one per cycle, no backpressure) and load unit (valid/ready).
- ALU has priority. Loads that lose arbitration wait in a small FIFO.
- Write-after-write hazards between a buffered load and a newer ALU result to the same rd are resolved inside this block.

Parameters:
- DATA_WIDTH, 32, width of result data and wr_data.
- LD_FIFO_DEPTH, 4, load buffer entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  load buffer can accept.
- ld_rd  in  5  load destination register.
- ld_data  in  DATA_WIDTH  load result.
- wr_en  out  1  register_file write enable.
- wr_index  out  5  register_file write index.
- wr_data  out  DATA_WIDTH  register_file write data.
- ld_pending  out  1  FIFO holds at least one entry.
- ld_count  out  $clog2(LD_FIFO_DEPTH)+1  FIFO occupancy.
- fwd_index1  in  5  forwarding lookup index for read port 1.
- fwd_index2  in  5  forwarding lookup index for read port 2.
- fwd_hit1  out  1  forwarding hit for port 1.
- fwd_hit2  out  1  forwarding hit for port 2.
- fwd_data1  out  DATA_WIDTH  forwarded data for port 1.
- fwd_data2  out  DATA_WIDTH  forwarded data for port 2.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - While reset is high: wr_en=0, wr_index=0, wr_data=0, FIFO emptied, ld_count=0, ld_pending=0, ld_ready=0, fwd_hit*=0, fwd_data*=0.
  - Reset mid-operation discards all buffered loads with no write.
  - ld_ready goes to 1 on the first cycle after reset deasserts.
- Handshake: load accepted on a clock edge with ld_valid && ld_ready. ld_ready = !reset && (ld_count < LD_FIFO_DEPTH).
  - ld_ready is not raised by a same-cycle drain; when full, the FIFO accepts nothing that cycle.
- Output register: wr_en/wr_index/wr_data are registered, 1-cycle latency from the selected source.
- Arbitration per cycle, in priority order:
  1. alu_valid with alu_rd != 0: ALU writes.
  2. Otherwise, FIFO non-empty: pop the head.
  3. Otherwise, load accepted with ld_rd != 0: bypass straight to the write port without enqueue.
  4. Otherwise: wr_en=0.
- Enqueue: an accepted load that does not bypass is enqueued at the tail. The FIFO drains strictly in order, oldest first.
- x0 rule: any result with rd=0 is dropped and never written. An accepted load with ld_rd=0 is acked but not enqueued.
- WAW kill: each FIFO entry carries a live bit.
  - When alu_valid with alu_rd != 0, every live entry whose rd == alu_rd is cleared.
  - A load accepted in the same cycle as an ALU result with the same nonzero rd is treated as older: it is acked and dropped.
  - Popping a dead entry consumes that cycle with wr_en=0.
- Simultaneous cases:
  - Pop plus enqueue on a non-full FIFO: ld_count unchanged.
  - ALU plus load with the FIFO empty: the load is enqueued, ALU written.
- Pointers: wrap modulo LD_FIFO_DEPTH. ld_count is the true occupancy, including dead entries.

Optional Feature:
- Macro: REG_WRITEBACK_FWD_EN.
- Defined: fwd_hitN = wr_en && wr_index != 0 && wr_index == fwd_indexN; fwd_dataN = wr_data when hit, else 0. Both are combinational from the output registers. This covers the register_file write-then-read cycle.
- Undefined: the ports remain; fwd_hit1/2 and fwd_data1/2 are tied to 0.

Test Plan:
1. Release reset; ALU writes rd=5, data 0x55 -> one cycle later wr_en=1, wr_index=5, wr_data=0x55; ld_ready=1.
2. FIFO empty, ALU idle, load rd=7, data 0xA7 -> bypass; next cycle wr_en=1, wr_index=7, wr_data=0xA7; ld_count stays 0.
3. ALU valid every cycle to rd=1..8 while loads rd=9..13 are offered -> 4 accepted, ld_ready=0, ld_count=4. After the ALU stops, writes 9,10,11,12 follow in order, then 13 after ld_ready returns.
4. Buffer load rd=3 data 0x33, then ALU rd=3 data 0x99 -> only 0x99 written to x3; the dead pop cycle has wr_en=0.
5. ALU rd=0 data 0xFF, and load rd=0 -> wr_en never asserted; load acked; ld_count=0.
6. With REG_WRITEBACK_FWD_EN: write rd=4 data 0x44, fwd_index1=4, fwd_index2=0 -> fwd_hit1=1, fwd_data1=0x44, fwd_hit2=0. Without the macro -> both hits 0.
